// File: rtl/pi2bpsk_sym_seq.sv
// pi/2-BPSK frame sequencer: serialises coded-bit words LSB-first into phase-wheel
// positions, one symbol per valid/ready handshake, framed between start and done.
module pi2bpsk_sym_seq #(
  parameter int CYC_DIV = 24,
  parameter int WORD_W  = 16,
  parameter int IDX_W   = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [IDX_W-1:0]  i_num_sym,
  input  logic [IDX_W-1:0]  i_start_idx,
  input  logic [WORD_W-1:0] i_bits,
  input  logic              i_bits_valid,
  output logic              o_bits_ready,
  output logic [4:0]        o_cyc_part,
  output logic [IDX_W-1:0]  o_sym_idx,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_last,
  output logic              o_busy,
  output logic              o_done
);

  localparam int CNT_W = $clog2(WORD_W + 1);

  localparam logic [4:0] PH_00 = 5'(CYC_DIV / 4 - CYC_DIV / 8);
  localparam logic [4:0] PH_01 = 5'(CYC_DIV / 2 - CYC_DIV / 8);
  localparam logic [4:0] PH_10 = 5'(3 * CYC_DIV / 4 - CYC_DIV / 8);
  localparam logic [4:0] PH_11 = 5'(CYC_DIV - CYC_DIV / 8);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t             state_reg;
  logic [WORD_W-1:0]  buf_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [IDX_W-1:0]   issue_rem_reg;
  logic [IDX_W-1:0]   idx_next_reg;
  logic               valid_reg;
  logic [4:0]         cyc_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic               last_reg;
  logic               busy_reg;
  logic               done_reg;

  logic               sym_xfer;
  logic               load;
  logic               bits_ready;
  logic               word_acc;
  logic [4:0]         phase_next;

  always_comb begin
    sym_xfer = valid_reg && i_ready;
    load     = (state_reg == RUN) && (cnt_reg != '0) && (issue_rem_reg != '0) &&
               (!valid_reg || i_ready);
    // A new word may be taken in the same cycle the last buffered bit is consumed,
    // which keeps the symbol stream gap-free across word boundaries.
    bits_ready = (state_reg == RUN) && (issue_rem_reg > IDX_W'(cnt_reg)) &&
                 ((cnt_reg == '0) || ((cnt_reg == CNT_W'(1)) && load));
    word_acc = bits_ready && i_bits_valid;

    phase_next = PH_00;
    case ({buf_reg[0], idx_next_reg[0]})
      2'b00:   phase_next = PH_00;
      2'b01:   phase_next = PH_01;
      2'b10:   phase_next = PH_10;
      default: phase_next = PH_11;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg     <= IDLE;
      buf_reg       <= '0;
      cnt_reg       <= '0;
      issue_rem_reg <= '0;
      idx_next_reg  <= '0;
      valid_reg     <= 1'b0;
      cyc_reg       <= '0;
      idx_reg       <= '0;
      last_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (i_start) begin
            issue_rem_reg <= i_num_sym;
            idx_next_reg  <= i_start_idx;
            busy_reg      <= 1'b1;
            if (i_num_sym == '0) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= RUN;
            end
          end
        end
        RUN: begin
          if (load) begin
            valid_reg     <= 1'b1;
            cyc_reg       <= phase_next;
            idx_reg       <= idx_next_reg;
            last_reg      <= (issue_rem_reg == IDX_W'(1));
            idx_next_reg  <= idx_next_reg + IDX_W'(1);
            issue_rem_reg <= issue_rem_reg - IDX_W'(1);
            if (issue_rem_reg == IDX_W'(1)) begin
              // Final symbol issued: leftover bits of this word are dropped.
              state_reg <= DRAIN;
              buf_reg   <= '0;
              cnt_reg   <= '0;
            end else if (word_acc) begin
              buf_reg <= i_bits;
              cnt_reg <= CNT_W'(WORD_W);
            end else begin
              buf_reg <= buf_reg >> 1;
              cnt_reg <= cnt_reg - CNT_W'(1);
            end
          end else begin
            if (sym_xfer) begin
              valid_reg <= 1'b0;
            end
            if (word_acc) begin
              buf_reg <= i_bits;
              cnt_reg <= CNT_W'(WORD_W);
            end
          end
        end
        DRAIN: begin
          if (sym_xfer) begin
            valid_reg <= 1'b0;
            last_reg  <= 1'b0;
            state_reg <= DONE;
            done_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign o_bits_ready = bits_ready;
  assign o_cyc_part   = cyc_reg;
  assign o_sym_idx    = idx_reg;
  assign o_valid      = valid_reg;
  assign o_last       = last_reg;
  assign o_busy       = busy_reg;
  assign o_done       = done_reg;

endmodule

// File: doc/pi2bpsk_sym_seq.md
Name: pi2bpsk_sym_seq

Overview:
Frame sequencer for pi/2-BPSK symbol generation in the PUCCH modulator. It accepts packed coded-bit words from upstream and serialises them LSB-first. It maintains the running symbol index and maps each (bit, index parity) pair to a phase-wheel position out of CYC_DIV. It emits one symbol per valid/ready handshake to the downstream phase/DAC stage and frames a programmable number of symbols between start and done.

Parameters:
CYC_DIV, 24, phase-wheel divisions; output = phase position in 0..CYC_DIV-1
WORD_W, 16, input bit-word width
IDX_W, 16, symbol index / symbol count width

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_start  in  1  frame start pulse; honoured in IDLE only
i_num_sym  in  IDX_W  symbols in frame; latched on accepted start
i_start_idx  in  IDX_W  index of first symbol; latched on accepted start
i_bits  in  WORD_W  coded bits, bit 0 consumed first
i_bits_valid  in  1  upstream word valid
o_bits_ready  out  1  word accepted when o_bits_ready && i_bits_valid
o_cyc_part  out  5  phase position of current symbol
o_sym_idx  out  IDX_W  index of current symbol
o_valid  out  1  symbol valid
i_ready  in  1  downstream ready; symbol transfers when o_valid && i_ready
o_last  out  1  current symbol is final symbol of frame
o_busy  out  1  high in every state except IDLE
o_done  out  1  one-cycle pulse at frame end

Behaviour:
- Clock and reset: single clock i_clk. Reset i_rst is synchronous and active-high.
- Reset values: all outputs are 0. State is IDLE. The bit buffer and all counters are cleared.
- Reset mid-frame: the frame is abandoned. The buffered word and any pending output symbol are discarded.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: on i_start, latch i_num_sym and i_start_idx.
  - If num_sym==0, go to DONE.
  - Otherwise, go to RUN.
- i_start outside IDLE is ignored.
- RUN: buffer holds one word plus a bit count (0..WORD_W).
  - issue_rem = number of symbols not yet loaded into the output register.
  - Symbol load condition: bit count>0 && issue_rem>0 && (!o_valid || i_ready).
  - On load, the output register takes:
    - the current bit b;
    - idx = start_idx + k, where k is the symbol number (mod 2^IDX_W, wraps);
    - o_cyc_part = phase(b, idx[0]);
    - o_last = (issue_rem==1).
  - On load, the buffer shifts right, bit count decrements and issue_rem decrements.
  - If a transfer occurs without a load, o_valid deasserts.
- o_bits_ready = RUN && issue_rem > bit count && (bit count==0 || (bit count==1 && load this cycle)).
  - This is combinational on i_ready and permits one symbol per cycle across word boundaries.
  - An accepted word sets bit count = WORD_W.
- Phase table, indexed by sel = {b, idx[0]}:
  - 00 -> CYC_DIV/4 - CYC_DIV/8
  - 01 -> CYC_DIV/2 - CYC_DIV/8
  - 10 -> 3*CYC_DIV/4 - CYC_DIV/8
  - 11 -> CYC_DIV - CYC_DIV/8
  - Integer division applies to each term separately. For CYC_DIV=24 the table is 3, 9, 15, 21.
- RUN -> DRAIN when the last symbol is loaded (issue_rem becomes 0).
  - Unused bits of the final word are discarded at that point and bit count clears.
- DRAIN: hold the output until the o_last symbol transfers, then go to DONE.
  - If the last load and its transfer coincide, still pass through DRAIN for one cycle.
- DONE: o_done=1 for exactly one cycle, then IDLE. o_busy=1 in DONE.
- Latency: word accepted in cycle t -> its first symbol has o_valid in cycle t+2.
- Throughput: one symbol per cycle with continuous i_bits_valid and i_ready.
- Backpressure: while o_valid && !i_ready, o_cyc_part, o_sym_idx and o_last are held stable and no symbol is dropped.

Test Plan:
1. start_idx=0, num_sym=4, word 0x000A, i_ready=1 -> (idx, cyc) = (0,3), (1,21), (2,3), (3,21); o_last on idx 3; o_done one cycle after the DRAIN cycle.
2. num_sym=20, two words 0xFFFF and 0x0000 presented back-to-back, i_ready=1 -> 20 consecutive valid cycles, no bubble at the word boundary; o_bits_ready low after the second word; 12 bits discarded; the 0x0000 symbols alternate 3 (even idx) and 9 (odd idx).
3. i_ready low for 3 cycles at symbol 5 of a 16-symbol frame -> outputs frozen for those cycles; all 16 indices delivered in order exactly once.
4. start_idx=0xFFFE, num_sym=3, word 0x0007 -> idx 0xFFFE, 0xFFFF, 0x0000 with cyc 15, 21, 15.
5. num_sym=0 -> o_busy high for one cycle (DONE) with o_done pulse; o_valid and o_bits_ready never asserted.
6. Assert i_rst at symbol 7 of a 16-symbol frame -> next cycle all outputs 0 and state IDLE; i_start pulsed in RUN is ignored; a fresh start after reset completes a full frame correctly.
